// File: rtl/pm_sequencer.sv
// pm_sequencer: picoMIPS filter control sequencer. It owns the PC, the circular sample pointers and the in/out handshakes.
// Latency: a sample accept gives the first EXEC strobe 1 cycle later; N instructions plus END give result_valid N+2 cycles after accept.
// Backpressure: sample_ready is high only in WAIT_IN; result_valid is held until result_ready; stop overrides every handshake.
// Build option: define PM_SEQ_ILLEGAL_TRAP_EN to send illegal opcodes to a TRAP state; by default an illegal opcode runs as a NOP.
module pm_sequencer #(
  parameter int PC_W   = 6,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              start,
  input  logic              stop,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [PC_W-1:0]   pc,
  input  logic [5:0]        opcode,
  input  logic [4:0]        offset,
  input  logic [4:0]        imm,
  output logic              sample_we,
  output logic [ADDR_W-1:0] sample_waddr,
  output logic [ADDR_W-1:0] sample_raddr,
  output logic [4:0]        coef_addr,
  output logic              acc_clr,
  output logic              mac_en,
  output logic              acc_wr,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              err
);

  // Samples and results flow through the memories and the MAC; this block only carries the width.
  if (DATA_W < 1) begin : g_bad_data_w
    $error("pm_sequencer: DATA_W must be at least 1");
  end

  localparam logic [5:0]      OP_NOP  = 6'b000000;
  localparam logic [5:0]      OP_MUL  = 6'b000001;
  localparam logic [5:0]      OP_ADD  = 6'b000010;
  localparam logic [5:0]      OP_END  = 6'b111111;
  localparam logic [PC_W-1:0] PC_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IN,
    S_EXEC,
`ifdef PM_SEQ_ILLEGAL_TRAP_EN
    S_TRAP,
`endif
    S_OUT
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] wr_ptr, cur_i, off_ext;
  logic is_mul, is_add, is_end, illegal, pc_last;

  assign is_mul  = (opcode == OP_MUL);
  assign is_add  = (opcode == OP_ADD);
  assign is_end  = (opcode == OP_END);
  assign illegal = !(is_mul || is_add || is_end || (opcode == OP_NOP));
  assign pc_last = (pc == PC_LAST);

  // Offsets are signed, so the buffer read address wraps in both directions.
  assign off_ext      = ADDR_W'(signed'(offset));
  assign sample_waddr = wr_ptr;

  // State register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state logic; stop beats every handshake in the same cycle
  always_comb begin
    next_state = state;
    if (stop) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) next_state = S_WAIT_IN;
        S_WAIT_IN: if (sample_valid) next_state = S_EXEC;
        S_EXEC: begin
`ifdef PM_SEQ_ILLEGAL_TRAP_EN
          if (illegal)                next_state = S_TRAP;
          else if (is_end || pc_last) next_state = S_OUT;
`else
          if (is_end || pc_last) next_state = S_OUT;
`endif
        end
        S_OUT:     if (result_ready) next_state = S_WAIT_IN;
`ifdef PM_SEQ_ILLEGAL_TRAP_EN
        S_TRAP:    next_state = S_TRAP;
`endif
        default:   next_state = S_IDLE;
      endcase
    end
  end

  // PC, buffer pointers and the sticky error flag
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pc     <= '0;
      wr_ptr <= '0;
      cur_i  <= '0;
      err    <= 1'b0;
    end else if (stop) begin
      pc <= '0;
    end else begin
      case (state)
        S_WAIT_IN: begin
          if (sample_valid) begin
            cur_i  <= wr_ptr;
            wr_ptr <= wr_ptr + ADDR_W'(1);
            pc     <= '0;
          end
        end
        S_EXEC: begin
          // A non-END instruction in the last ROM slot is an overrun: it still runs, but the PC holds.
          if (illegal || (pc_last && !is_end)) err <= 1'b1;
`ifdef PM_SEQ_ILLEGAL_TRAP_EN
          if (!is_end && !pc_last && !illegal) pc <= pc + PC_W'(1);
`else
          if (!is_end && !pc_last) pc <= pc + PC_W'(1);
`endif
        end
        default: ;
      endcase
    end
  end

  // Output decode: the strobes come from the state and the current opcode
  always_comb begin
    sample_ready = 1'b0;
    sample_we    = 1'b0;
    acc_clr      = 1'b0;
    mac_en       = 1'b0;
    acc_wr       = 1'b0;
    result_valid = 1'b0;
    sample_raddr = '0;
    coef_addr    = '0;
    case (state)
      S_WAIT_IN: begin
        sample_ready = !stop;
        sample_we    = sample_valid && !stop;
        acc_clr      = sample_valid && !stop;
      end
      S_EXEC: begin
        mac_en       = is_mul;
        acc_wr       = is_add;
        sample_raddr = cur_i + off_ext;
        coef_addr    = imm;
      end
      S_OUT:   result_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
